axis2fifo: RTL and testbench
============================

# axis2fifo

Upstream neighbour of the S2MM FIFO-to-memory writer. Accepts a one-pixel-per-beat AXI4-Stream video input (tuser = start of frame, tlast = end of line). Packs C_ADATA_PIXELS pixels into one memory word and writes packed words, each with a per-word sof flag, into the S2MM data FIFO. Aligns to frame starts, enforces the frame geometry, and honours the shared soft reset so the FIFO never receives a partial frame head.

## Interface
- C_PIXEL_WIDTH, 8, bits per pixel
- C_ADATA_PIXELS, 4, pixels per packed word; power of two
- C_M_AXI_DATA_WIDTH, 32, packed word width; must equal C_PIXEL_WIDTH*C_ADATA_PIXELS
- C_IMG_WBITS, 12, width of img_width
- C_IMG_HBITS, 12, width of img_height

Ports:
- S_AXIS_ACLK  in  1  sole clock
- S_AXIS_ARESETN  in  1  asynchronous active-low reset
- soft_resetn  in  1  synchronous soft reset, active low
- resetting  out  1  high while in IDLE
- img_width  in  C_IMG_WBITS  pixels per line; nonzero multiple of C_ADATA_PIXELS
- img_height  in  C_IMG_HBITS  lines per frame; nonzero
- s_axis_tvalid  in  1  stream valid
- s_axis_tdata  in  C_PIXEL_WIDTH  pixel
- s_axis_tuser  in  1  first pixel of frame
- s_axis_tlast  in  1  last pixel of line
- s_axis_tready  out  1  stream ready
- fifo_wr_en  out  1  FIFO write strobe
- fifo_data  out  C_M_AXI_DATA_WIDTH  packed word; pixel k at bits [k*C_PIXEL_WIDTH +: C_PIXEL_WIDTH], k=0 is the earliest pixel
- fifo_sof  out  1  word holds pixel (0,0)
- fifo_full  in  1  FIFO full
- frame_done  out  1  one-cycle pulse when the frame's last word is written
- err_line  out  1  one-cycle pulse on a geometry violation

## Operation
- Accept = s_axis_tvalid & s_axis_tready. Write = fifo_wr_en, which is out_valid & ~fifo_full.
- States:
  - IDLE: tready=0. Moves to SYNC when soft_resetn=1, img_width≠0 and img_height≠0. Latches img_width and img_height on exit; mid-frame changes are ignored.
  - SYNC: tready = ~out_valid | ~fifo_full. Accepted beats with tuser=0 are dropped. An accepted beat with tuser=1 is pixel (0,0) and moves the block to RUN.
  - RUN: counts col 0..W-1 and row 0..H-1. When the beat at (W-1,H-1) is accepted, the block returns to SYNC and that word is tagged eof.
- Packing:
  - A lane index (log2(C_ADATA_PIXELS) bits) wraps to 0.
  - When the lane reaches C_ADATA_PIXELS-1, the assembled word loads an output register with out_valid=1.
  - The sof tag is set if the word contains pixel (0,0). The eof tag is set if it contains pixel (W-1,H-1).
- Output register:
  - Holds one word. It is released by a write.
  - It reloads in the same cycle as a write (full throughput, one pixel per clock).
- Backpressure: tready=0 only when out_valid & fifo_full, or in IDLE. Pixels are never lost once accepted.
- soft_resetn=0 in any state: next cycle the block is in IDLE. out_valid, lane, col, row and the partial word are cleared. Nothing further is written.

## Timing
- All outputs reset to 0 except resetting, which resets to 1.
- Latency: fifo_wr_en rises the cycle after the accept of the word's last pixel, if fifo_full=0.
- fifo_data and fifo_sof are stable while fifo_wr_en is held by fifo_full.
- frame_done is asserted in the same cycle as the write of the eof-tagged word.
- err_line is asserted the cycle after the offending accept.
- If soft_resetn falls in the same cycle as a write, that write completes and a pending frame_done is suppressed.

## Configuration
- Macro: AXIS2FIFO_LINE_CHECK_EN.
- Defined, in RUN:
  - Line-length check: a mismatch is tlast=1 with col≠W-1, or tlast=0 with col=W-1. On a mismatch, err_line pulses, the partial word and any unwritten out_valid word are discarded, and the block enters SYNC.
  - Mid-frame restart: an accepted tuser=1 at a position other than (0,0) pulses err_line and restarts the frame, with that beat taken as pixel (0,0).
- Undefined: tlast is ignored; tuser is ignored in RUN; err_line is tied to 0; frame geometry comes from counting only.

## Test plan
- 8x2 frame, C_ADATA_PIXELS=4, pixels 0x00..0x0F, no stalls: 4 writes with data 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; fifo_sof=1 on the first only; frame_done on the 4th write.
- 3 beats with tuser=0, then a frame starting with tuser=1: the 3 beats are dropped; the first write carries fifo_sof=1 and lane 0 equals the tuser pixel.
- fifo_full held high for 10 cycles mid-frame: tready falls once out_valid is set; no pixel is lost or duplicated; the data sequence is identical to the no-stall run.
- soft_resetn pulsed low for 1 cycle after 5 pixels: resetting=1 and no write occurs. After release, the next tuser frame packs from lane 0.
- With AXIS2FIFO_LINE_CHECK_EN, W=8, tlast on col 5: err_line pulses once; the next tuser frame writes normally. Without the macro: no err_line, and 4 words are written.
- 8x1 frame followed immediately by a second frame with no idle cycles: 4 writes with frame_done on the 2nd and 4th, and fifo_sof on the 1st and 3rd.

Source files
------------

// File: rtl/axis2fifo.sv
// axis2fifo: packs AXI4-Stream video pixels into S2MM FIFO words with sof tags; define AXIS2FIFO_LINE_CHECK_EN to enable line-length and mid-frame restart checks
module axis2fifo #(
  parameter int C_PIXEL_WIDTH      = 8,
  parameter int C_ADATA_PIXELS     = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_IMG_WBITS        = 12,
  parameter int C_IMG_HBITS        = 12
) (
  input  logic                          S_AXIS_ACLK,
  input  logic                          S_AXIS_ARESETN,
  input  logic                          soft_resetn,
  output logic                          resetting,
  input  logic [C_IMG_WBITS-1:0]        img_width,
  input  logic [C_IMG_HBITS-1:0]        img_height,
  input  logic                          s_axis_tvalid,
  input  logic [C_PIXEL_WIDTH-1:0]      s_axis_tdata,
  input  logic                          s_axis_tuser,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic                          fifo_wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0] fifo_data,
  output logic                          fifo_sof,
  input  logic                          fifo_full,
  output logic                          frame_done,
  output logic                          err_line
);
  localparam int LW = C_ADATA_PIXELS > 1 ? $clog2(C_ADATA_PIXELS) : 1;
  localparam logic [LW-1:0] LMAX = LW'(C_ADATA_PIXELS - 1);
  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
  state_t state, state_nx;
  logic [C_IMG_WBITS-1:0] w_q, col, pcol, col_nx;
  logic [C_IMG_HBITS-1:0] h_q, row, prow, row_nx;
  logic [LW-1:0] lane, plane;
  logic [C_M_AXI_DATA_WIDTH-1:0] part, word;
  logic sof_acc, word_sof, out_valid, out_eof;
  logic acc, start, restart, mismatch, pack, last_col, last_pix;
  assign s_axis_tready = (state != IDLE) & (~out_valid | ~fifo_full);
  assign acc = s_axis_tvalid & s_axis_tready;
  assign fifo_wr_en = out_valid & ~fifo_full;
  assign frame_done = fifo_wr_en & out_eof & soft_resetn;
  assign resetting = state == IDLE;
`ifdef AXIS2FIFO_LINE_CHECK_EN
  assign restart = acc & (state == RUN) & s_axis_tuser & ((col != '0) | (row != '0));
  assign mismatch = acc & (state == RUN) & ~restart & (s_axis_tlast != (col == w_q - 1'b1));
  // geometry violations are reported one cycle after the offending beat
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN)
    if (!S_AXIS_ARESETN) err_line <= 1'b0;
    else err_line <= soft_resetn & (restart | mismatch);
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign restart = 1'b0;
  assign mismatch = 1'b0;
  assign err_line = 1'b0;
`endif
  // position of the current beat, packed word and next state
  always_comb begin
    start = (acc & (state == SYNC) & s_axis_tuser) | restart;
    pack = acc & ~mismatch & (start | (state == RUN));
    pcol = start ? '0 : col;
    prow = start ? '0 : row;
    plane = start ? '0 : lane;
    last_col = pcol == w_q - 1'b1;
    last_pix = last_col & (prow == h_q - 1'b1);
    col_nx = last_col ? '0 : pcol + 1'b1;
    row_nx = last_col ? (last_pix ? '0 : prow + 1'b1) : prow;
    word = part;
    word[int'(plane)*C_PIXEL_WIDTH +: C_PIXEL_WIDTH] = s_axis_tdata;
    word_sof = (plane == '0) ? start : sof_acc;
    state_nx = ~soft_resetn ? IDLE :
               (state == IDLE) ? (((img_width != '0) & (img_height != '0)) ? SYNC : IDLE) :
               mismatch ? SYNC :
               pack ? (last_pix ? SYNC : RUN) : state;
  end
  // state register
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN)
    if (!S_AXIS_ARESETN) state <= IDLE;
    else state <= state_nx;
  // geometry latch, frame counters, lane packing and output word register
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      w_q <= '0;
      h_q <= '0;
      col <= '0;
      row <= '0;
      lane <= '0;
      part <= '0;
      sof_acc <= 1'b0;
      out_valid <= 1'b0;
      out_eof <= 1'b0;
      fifo_data <= '0;
      fifo_sof <= 1'b0;
    end else if (!soft_resetn) begin
      col <= '0;
      row <= '0;
      lane <= '0;
      part <= '0;
      sof_acc <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (state == IDLE) begin
        w_q <= img_width;
        h_q <= img_height;
      end
      if (mismatch) begin
        lane <= '0;
        part <= '0;
        sof_acc <= 1'b0;
        out_valid <= 1'b0;
      end else if (pack) begin
        col <= col_nx;
        row <= row_nx;
        lane <= (plane == LMAX) ? '0 : plane + 1'b1;
        part <= word;
        sof_acc <= word_sof;
        if (plane == LMAX) begin
          out_valid <= 1'b1;
          fifo_data <= word;
          fifo_sof <= word_sof;
          out_eof <= last_pix;
        end else if (fifo_wr_en) out_valid <= 1'b0;
      end else if (fifo_wr_en) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axis2fifo.sv
// tb_axis2fifo: scoreboard bench for axis2fifo packing, sync, stalls, soft reset and geometry checks
`timescale 1ns/1ps
module tb_axis2fifo;
  logic clk = 0, rst_n = 0, soft_resetn = 0;
  logic [11:0] img_width = 12'd8, img_height = 12'd2;
  logic tvalid = 0, tuser = 0, tlast = 0, full = 0;
  logic [7:0] tdata = 0;
  logic tready, wr_en, sof, done, err, resetting;
  logic [31:0] data;
  logic [33:0] exp_q[$];
  logic [33:0] e;
  int vectors = 0, miscompares = 0, err_cnt = 0;

  always #5 clk = ~clk;

  axis2fifo dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .soft_resetn(soft_resetn), .resetting(resetting),
    .img_width(img_width), .img_height(img_height), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
    .s_axis_tuser(tuser), .s_axis_tlast(tlast), .s_axis_tready(tready), .fifo_wr_en(wr_en),
    .fifo_data(data), .fifo_sof(sof), .fifo_full(full), .frame_done(done), .err_line(err)
  );

  // scoreboard: every write is popped and compared as {sof, frame_done, data}
  always @(negedge clk) begin
    if (err) err_cnt++;
    if (wr_en) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got sof=%b done=%b data=%h, required no write", sof, done, data);
      end else begin
        e = exp_q.pop_front();
        if ({sof, done, data} !== e) begin
          miscompares++;
          $display("FAIL write: got sof=%b done=%b data=%h, required sof=%b done=%b data=%h",
                   sof, done, data, e[33], e[32], e[31:0]);
        end
      end
    end else if (done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_without_write: got frame_done=1, required 0");
    end
  end

  task automatic send(input logic [7:0] d, input logic u, input logic l);
    logic a;
    int n = 0;
    tvalid = 1; tdata = d; tuser = u; tlast = l;
    do begin
      @(negedge clk); a = tready;
      @(posedge clk); #1; n++;
    end while (!a && n < 200);
    if (!a) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: tready=0, required 1 within 200 cycles");
    end
    tvalid = 0;
  endtask

  task automatic send_frame(input int w, input int h, input logic [7:0] base);
    for (int i = 0; i < w * h; i++) send(base + 8'(i), i == 0, (i % w) == w - 1);
  endtask

  task automatic push_frame(input int w, input int h, input logic [7:0] base);
    int n = w * h;
    for (int k = 0; k < n; k += 4) begin
      logic [31:0] d = '0;
      for (int j = 0; j < 4; j++) d[j*8 +: 8] = base + 8'(k + j);
      exp_q.push_back({k == 0, k + 4 == n, d});
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d words still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic reconfig(input logic [11:0] w, input logic [11:0] h);
    img_width = w; img_height = h; soft_resetn = 0;
    @(posedge clk); #1 soft_resetn = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if ({resetting, tready, wr_en, sof, done, err} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 100000", {resetting, tready, wr_en, sof, done, err});
    end
    vectors++;
    if (data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h, required 00000000", data);
    end
    rst_n = 1; soft_resetn = 1;
    @(posedge clk); @(negedge clk);
    vectors++;
    if ({resetting, tready} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_exit: got resetting,tready=%b, required 01", {resetting, tready});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    exp_q.push_back({2'b10, 32'h03020100});
    exp_q.push_back({2'b00, 32'h07060504});
    exp_q.push_back({2'b00, 32'h0B0A0908});
    exp_q.push_back({2'b01, 32'h0F0E0D0C});
    send_frame(8, 2, 8'h00);
    drain("basic");
  endtask

  task automatic test_sync_drop;
    for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 1'b0, 1'b0);
    push_frame(8, 2, 8'h20);
    send_frame(8, 2, 8'h20);
    drain("sync_drop");
  endtask

  task automatic test_stall;
    push_frame(8, 2, 8'h00);
    fork
      send_frame(8, 2, 8'h00);
      begin
        repeat (6) @(posedge clk);
        #1 full = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({tready, wr_en} !== 2'b00) begin
          miscompares++;
          $display("FAIL stall_ready: got tready,wr_en=%b, required 00", {tready, wr_en});
        end
        @(posedge clk); #1 full = 0;
      end
    join
    drain("stall");
  endtask

  task automatic test_soft_reset;
    exp_q.push_back({2'b10, 32'h03020100});
    for (int i = 0; i < 5; i++) send(8'(i), i == 0, 1'b0);
    soft_resetn = 0;
    @(posedge clk); #1 soft_resetn = 1;
    @(negedge clk);
    vectors++;
    if ({resetting, tready} !== 2'b10) begin
      miscompares++;
      $display("FAIL soft_reset_idle: got resetting,tready=%b, required 10", {resetting, tready});
    end
    drain("soft_reset_head");
    push_frame(8, 2, 8'h40);
    send_frame(8, 2, 8'h40);
    drain("soft_reset_next");
  endtask

  task automatic test_line_check;
    int e0 = err_cnt, exp_err;
`ifdef AXIS2FIFO_LINE_CHECK_EN
    exp_err = 1;
    exp_q.push_back({2'b10, 32'h83828180});
`else
    exp_err = 0;
    push_frame(8, 2, 8'h80);
`endif
    for (int i = 0; i < 16; i++) send(8'h80 + 8'(i), i == 0, i == 5 || i == 15);
    drain("line_bad");
    vectors++;
    if (err_cnt - e0 !== exp_err) begin
      miscompares++;
      $display("FAIL line_err_count: got %0d pulses, required %0d", err_cnt - e0, exp_err);
    end
    push_frame(8, 2, 8'h90);
    send_frame(8, 2, 8'h90);
    drain("line_next");
    vectors++;
    if (err_cnt - e0 !== exp_err) begin
      miscompares++;
      $display("FAIL line_err_after: got %0d pulses, required %0d", err_cnt - e0, exp_err);
    end
  endtask

  task automatic test_back_to_back;
    reconfig(12'd8, 12'd1);
    push_frame(8, 1, 8'hB0);
    push_frame(8, 1, 8'hC0);
    send_frame(8, 1, 8'hB0);
    send_frame(8, 1, 8'hC0);
    drain("back_to_back");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_sync_drop;
    test_stall;
    test_soft_reset;
    test_line_check;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
